// File: rtl/parity_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : parity_tx_scheduler_if
//  Purpose  : Requester-side bus and serial link signals of the shared
//             parity transmitter. The master modport is the requester/link
//             side and the slave modport is the scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
interface parity_tx_scheduler_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 3
);
    localparam int c_idw = $clog2(NREQ);

    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] data_in;
    logic [NREQ-1:0]        gnt;
    logic                   ser_out;
    logic                   ser_valid;
    logic                   frame_start;
    logic [c_idw-1:0]       src_id;
    logic                   busy;

    modport master (
        output req, data_in,
        input  gnt, ser_out, ser_valid, frame_start, src_id, busy
    );

    modport slave (
        input  req, data_in,
        output gnt, ser_out, ser_valid, frame_start, src_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/parity_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : parity_tx_scheduler
//  Purpose  : Round-robin scheduler sharing one even-parity encoder and one
//             serial lane among NREQ requesters. The granted word is sent
//             LSB-first as {parity, data}, with a valid strobe and a frame
//             marker on the first bit.
//  Options  : PARITY_TX_STOP_BIT_EN - append a constant-1 stop bit after the
//             parity bit.
//  Revision : 1.0 - initial release
// ============================================================================
module parity_tx_scheduler #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 3
) (
    input wire logic              clk,
    input wire logic              rst,
    parity_tx_scheduler_if.slave  bus
);
    localparam int c_idw = $clog2(NREQ);
`ifdef PARITY_TX_STOP_BIT_EN
    localparam int c_cw = DATA_W + 2;
`else
    localparam int c_cw = DATA_W + 1;
`endif
    localparam int                 c_cnt_w = $clog2(c_cw);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(c_cw - 1);
    localparam logic [c_idw-1:0]   c_top   = c_idw'(NREQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_idw-1:0]   r_ptr;
    logic [c_idw-1:0]   r_src_id;
    logic [c_cw-1:0]    r_shift;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_ser_out;
    logic               r_ser_valid;
    logic               r_frame_start;
    logic               r_busy;

    logic [c_idw-1:0]   w_cand [NREQ];
    logic               w_found;
    logic [c_idw-1:0]   w_idx;
    logic [NREQ-1:0]    w_gnt;
    logic [DATA_W-1:0]  w_word;
    logic [c_cw-1:0]    w_code;
    logic [c_idw-1:0]   w_next_ptr;

    // Candidate k is the requester k positions above the pointer, wrapped
    // explicitly so non-power-of-two NREQ returns to 0 after NREQ-1.
    generate
        for (genvar k = 0; k < NREQ; k++) begin : g_cand
            logic [c_idw:0] w_sum;
            assign w_sum     = {1'b0, r_ptr} + (c_idw + 1)'(k);
            assign w_cand[k] = (w_sum >= (c_idw + 1)'(NREQ))
                             ? c_idw'(w_sum - (c_idw + 1)'(NREQ))
                             : c_idw'(w_sum);
        end
    endgenerate

    // Pick the first requesting candidate; scanning downward lets the
    // lowest offset from the pointer win.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[w_cand[k]]) begin
                w_found = 1'b1;
                w_idx   = w_cand[k];
            end
        end
    end

    // Grant is only offered while arbitrating; the lane is busy otherwise.
    always_comb begin
        w_gnt = '0;
        if (r_state == ST_IDLE && w_found) begin
            w_gnt[w_idx] = 1'b1;
        end
    end

    assign w_word     = bus.data_in[w_idx*DATA_W +: DATA_W];
`ifdef PARITY_TX_STOP_BIT_EN
    assign w_code     = {1'b1, ^w_word, w_word};
`else
    assign w_code     = {^w_word, w_word};
`endif
    assign w_next_ptr = (w_idx == c_top) ? '0 : w_idx + 1'b1;

    // Arbitration / shift FSM; all link outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_src_id      <= '0;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_ser_out     <= 1'b0;
            r_ser_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        // Bit 0 goes straight to the output; the rest waits
                        // in the shift register.
                        r_state       <= ST_SHIFT;
                        r_ptr         <= w_next_ptr;
                        r_src_id      <= w_idx;
                        r_shift       <= w_code >> 1;
                        r_cnt         <= '0;
                        r_ser_out     <= w_code[0];
                        r_ser_valid   <= 1'b1;
                        r_frame_start <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_frame_start <= 1'b0;
                    if (r_cnt == c_last) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        r_ser_out   <= 1'b0;
                        r_ser_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end else begin
                        r_cnt     <= r_cnt + 1'b1;
                        r_ser_out <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt         = w_gnt;
    assign bus.ser_out     = r_ser_out;
    assign bus.ser_valid   = r_ser_valid;
    assign bus.frame_start = r_frame_start;
    assign bus.src_id      = r_src_id;
    assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_parity_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_parity_tx_scheduler
//  Purpose  : Scoreboard bench for parity_tx_scheduler. Stimulus pushes the
//             hand-computed grants and frame bits; a negedge monitor pops
//             and compares whatever the DUT presents.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_parity_tx_scheduler;
    localparam int NREQ   = 4;
    localparam int DATA_W = 3;
`ifdef PARITY_TX_STOP_BIT_EN
    localparam int PERIOD = DATA_W + 3;
`else
    localparam int PERIOD = DATA_W + 2;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    parity_tx_scheduler_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

    parity_tx_scheduler #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic [3:0] g; int gap; } gexp_t;
    typedef struct { logic b; logic fs; logic [1:0] id; } bexp_t;

    gexp_t gq[$];
    bexp_t bq[$];
    gexp_t mon_ge;
    bexp_t mon_be;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_gnt_cyc = 0;
    bit mon_en = 1'b0;

    // Codewords {parity, word} for words 0..7, worked out by hand.
    logic [3:0] cw_tab [8] = '{4'b0000, 4'b1001, 4'b1010, 4'b0011,
                               4'b1100, 4'b0101, 4'b0110, 4'b1111};

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every presented grant and every valid bit.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (bus.busy !== bus.ser_valid) begin
                errors++;
                $display("FAIL busy_eq_valid: busy=%b ser_valid=%b required equal", bus.busy, bus.ser_valid);
            end
            if (bus.busy === 1'b1) begin
                checks++;
                if (bus.gnt !== 4'b0000) begin
                    errors++;
                    $display("FAIL gnt_in_shift: gnt=%b required 0000", bus.gnt);
                end
            end else if (bus.gnt !== 4'b0000) begin
                checks++;
                if (gq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_gnt: gnt=%b required 0000", bus.gnt);
                end else begin
                    mon_ge = gq.pop_front();
                    if (bus.gnt !== mon_ge.g) begin
                        errors++;
                        $display("FAIL gnt: gnt=%b required %b", bus.gnt, mon_ge.g);
                    end
                    if (mon_ge.gap != 0) begin
                        checks++;
                        if (cyc - last_gnt_cyc != mon_ge.gap) begin
                            errors++;
                            $display("FAIL gnt_period: got %0d cycles required %0d", cyc - last_gnt_cyc, mon_ge.gap);
                        end
                    end
                end
                last_gnt_cyc = cyc;
            end
            checks++;
            if (bus.ser_valid === 1'b1) begin
                if (bq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bit: ser_out=%b with no frame expected", bus.ser_out);
                end else begin
                    mon_be = bq.pop_front();
                    if ({bus.ser_out, bus.frame_start, bus.src_id} !== {mon_be.b, mon_be.fs, mon_be.id}) begin
                        errors++;
                        $display("FAIL frame_bit: ser_out=%b frame_start=%b src_id=%0d required %b %b %0d",
                                 bus.ser_out, bus.frame_start, bus.src_id, mon_be.b, mon_be.fs, mon_be.id);
                    end
                end
            end else if (bus.frame_start !== 1'b0) begin
                errors++;
                $display("FAIL frame_start_idle: frame_start=%b required 0", bus.frame_start);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Queue one grant and the first nbits of its codeword (plus stop bit
    // when the full frame is expected).
    task automatic push_frame(input logic [3:0] g, input logic [1:0] id, input logic [3:0] cw,
                              input int gap, input int nbits);
        gexp_t ge;
        bexp_t be;
        ge.g   = g;
        ge.gap = gap;
        gq.push_back(ge);
        for (int i = 0; i < nbits; i++) begin
            be.b  = cw[i];
            be.fs = (i == 0);
            be.id = id;
            bq.push_back(be);
        end
`ifdef PARITY_TX_STOP_BIT_EN
        if (nbits == DATA_W + 1) begin
            be.b  = 1'b1;
            be.fs = 1'b0;
            be.id = id;
            bq.push_back(be);
        end
`endif
    endtask

    task automatic wait_gnt(input string tag);
        int n = 0;
        #1;
        while (bus.gnt === 4'b0000 && n < 30) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (bus.gnt === 4'b0000) begin
            errors++;
            $display("FAIL %s_gnt_timeout: gnt=%b required nonzero within 30 cycles", tag, bus.gnt);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((bus.busy !== 1'b0 || bq.size() != 0 || gq.size() != 0) && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0 || bq.size() != 0 || gq.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: busy=%b pending bits=%0d grants=%0d required 0", tag, bus.busy, bq.size(), gq.size());
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = '0;
        step();
        step();
        rst     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.req     = '0;
        bus.data_in = '0;
        step();
        step();
        chk("rst_ser_valid", 32'(bus.ser_valid), 32'd0);
        chk("rst_ser_out", 32'(bus.ser_out), 32'd0);
        chk("rst_frame_start", 32'(bus.frame_start), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_src_id", 32'(bus.src_id), 32'd0);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        mon_en = 1'b1;
        rst    = 1'b0;

        // Single frame, word 011, then scramble inputs mid-frame.
        bus.data_in = 12'b000_000_000_011;
        bus.req     = 4'b0001;
        push_frame(4'b0001, 2'd0, 4'b0011, 0, 4);
        wait_gnt("t1");
        step();
        bus.req     = 4'b0000;
        bus.data_in = 12'hFFF;
        wait_idle("t1");

        // All eight words from requester 0, back to back.
        bus.req = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            bus.data_in = {9'b0, 3'(k)};
            push_frame(4'b0001, 2'd0, cw_tab[k], (k == 0) ? 0 : PERIOD, 4);
            wait_gnt("t2");
            step();
        end
        bus.req = 4'b0000;
        wait_idle("t2");

        // Round robin with all four requesting.
        do_reset();
        bus.data_in = {3'b100, 3'b110, 3'b001, 3'b011};
        bus.req     = 4'b1111;
        push_frame(4'b0001, 2'd0, 4'b0011, 0, 4);
        wait_gnt("t3a");
        step();
        push_frame(4'b0010, 2'd1, 4'b1001, PERIOD, 4);
        wait_gnt("t3b");
        step();
        push_frame(4'b0100, 2'd2, 4'b0110, PERIOD, 4);
        wait_gnt("t3c");
        step();
        push_frame(4'b1000, 2'd3, 4'b1100, PERIOD, 4);
        wait_gnt("t3d");
        step();
        push_frame(4'b0001, 2'd0, 4'b0011, PERIOD, 4);
        wait_gnt("t3e");
        step();
        bus.req = 4'b0000;
        wait_idle("t3");

        // Pointer skip; requests raised mid-frame wait for IDLE.
        do_reset();
        bus.data_in = {3'b111, 3'b010, 3'b000, 3'b101};
        bus.req     = 4'b0001;
        push_frame(4'b0001, 2'd0, 4'b0101, 0, 4);
        wait_gnt("t4a");
        step();
        bus.req = 4'b0101;
        push_frame(4'b0100, 2'd2, 4'b1010, PERIOD, 4);
        wait_gnt("t4b");
        step();
        push_frame(4'b0001, 2'd0, 4'b0101, PERIOD, 4);
        wait_gnt("t4c");
        step();
        bus.req = 4'b1000;
        push_frame(4'b1000, 2'd3, 4'b1111, PERIOD, 4);
        wait_gnt("t4d");
        step();
        bus.req = 4'b0000;
        wait_idle("t4");

        // Reset on the second frame bit aborts the frame and the pointer.
        do_reset();
        bus.data_in = {3'b100, 3'b110, 3'b001, 3'b011};
        bus.req     = 4'b1111;
        push_frame(4'b0001, 2'd0, 4'b0011, 0, 2);
        wait_gnt("t5a");
        step();
        step();
        rst     = 1'b1;
        bus.req = 4'b0000;
        step();
        rst = 1'b0;
        chk("abort_ser_valid", 32'(bus.ser_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_frame_start", 32'(bus.frame_start), 32'd0);
        chk("abort_ser_out", 32'(bus.ser_out), 32'd0);
        chk("abort_src_id", 32'(bus.src_id), 32'd0);
        bus.req = 4'b1111;
        push_frame(4'b0001, 2'd0, 4'b0011, 0, 4);
        wait_gnt("t5b");
        step();
        bus.req = 4'b0000;
        wait_idle("t5");

        step();
        checks++;
        if (gq.size() != 0 || bq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: grants=%0d bits=%0d required 0", gq.size(), bq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
